// File: rtl/matmul_apb_pkg.sv
// Shared definitions for the matmul APB initiator: FSM encoding, default
// bus geometry and the register-region map of the matmul slave.
package matmul_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned DEF_BUS_WIDTH  = 32;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    REG_CONTROL   = 3'd0,
    REG_OPERAND_A = 3'd1,
    REG_OPERAND_B = 3'd2,
    REG_FLAGS     = 3'd3,
    REG_SP1       = 3'd4,
    REG_SP2       = 3'd5,
    REG_SP3       = 3'd6,
    REG_SP4       = 3'd7
  } reg_region_e;

  // Region index sits at paddr[4+SPA:2+SPA]; wider element packing shifts it up.
  function automatic int unsigned region_lsb(input int unsigned bus_w, input int unsigned data_w);
    return ((bus_w / data_w) > 2) ? 6 : 4;
  endfunction

  function automatic reg_region_e region_of(input logic [31:0] addr, input int unsigned lsb);
    logic [31:0] sh;
    sh = addr >> lsb;
    return reg_region_e'(sh[2:0]);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-cycle counter; expire flags the increment that reaches LIMIT.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int unsigned CW = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM_M1 = CW'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam bit ENABLED = (LIMIT != 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign expire = ENABLED && inc && (count == LIM_M1);

endmodule

// File: rtl/matmul_apb_master.sv
// APB initiator: one command at a time through SETUP/ACCESS, with wait
// states, slave error and an optional ACCESS timeout reported on the response port.
module matmul_apb_master
  import matmul_apb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            rsp_timeout_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [BUS_WIDTH-1:0]            pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
  input  logic [BUS_WIDTH-1:0]            prdata_i,
  input  logic                            pready_i,
  input  logic                            pslverr_i
);

  apb_state_e state, state_nxt;
  logic accept, finish, timed_out, handshake, expire;

  apb_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (accept),
    .inc    (state == ST_ACCESS),
    .expire (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    handshake = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // pready wins over a timeout landing on the same edge
        if (pready_i) begin
          finish    = 1'b1;
          state_nxt = ST_RESP;
        end else if (expire) begin
          timed_out = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          handshake = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
    end else begin
      if (accept) begin
        cmd_ready_o <= 1'b0;
        psel_o      <= 1'b1;
        pwrite_o    <= cmd_write_i;
        paddr_o     <= cmd_addr_i;
        pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
        pstrb_o     <= cmd_write_i ? cmd_strb_i : '0;
      end
      if (state == ST_SETUP) penable_o <= 1'b1;
      if (finish || timed_out) begin
        psel_o        <= 1'b0;
        penable_o     <= 1'b0;
        rsp_valid_o   <= 1'b1;
        rsp_err_o     <= timed_out ? 1'b1 : pslverr_i;
        rsp_timeout_o <= timed_out;
        rsp_rdata_o   <= (finish && !pwrite_o) ? prdata_i : '0;
      end
      if (handshake) begin
        rsp_valid_o <= 1'b0;
        cmd_ready_o <= 1'b1;
      end
    end
  end

endmodule
